// File: rtl/enc_8b10b.sv
// 8b/10b encoder with a one-deep registered output stage and valid/ready handshake.
// Running disparity advances only when a word is accepted; illegal K requests emit K28.5 flagged by code_err.
module enc_8b10b #(
  parameter logic INIT_RD = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] data,
  input  logic       control,
  output logic [9:0] data_10b,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       code_err,
  output logic       rd
);

  logic       accept;
  logic       k_legal;
  logic       err_nxt;
  logic [4:0] x5;
  logic [2:0] y3;
  logic [5:0] m6;
  logic [5:0] p6;
  logic [5:0] sb6;
  logic       rd_mid;
  logic       use_alt;
  logic [3:0] m4;
  logic [3:0] p4;
  logic [3:0] sb4;
  logic       rd_new;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Illegal K requests are substituted with K28.5 before table lookup.
  always_comb begin
    k_legal = (data[4:0] == 5'd28) || (data == 8'hF7) || (data == 8'hFB) ||
              (data == 8'hFD) || (data == 8'hFE);
    err_nxt = control && !k_legal;
    x5      = err_nxt ? 5'd28 : data[4:0];
    y3      = err_nxt ? 3'd5  : data[7:5];
  end

  // 5b/6b: RD- column in m6, RD+ column in p6 (abcdei).
  always_comb begin
    m6 = 6'b000000;
    p6 = 6'b000000;
    if (control && (x5 == 5'd28)) begin
      m6 = 6'b001111;
      p6 = 6'b110000;
    end else begin
      case (x5)
        5'd0:  begin m6 = 6'b100111; p6 = 6'b011000; end
        5'd1:  begin m6 = 6'b011101; p6 = 6'b100010; end
        5'd2:  begin m6 = 6'b101101; p6 = 6'b010010; end
        5'd3:  begin m6 = 6'b110001; p6 = 6'b110001; end
        5'd4:  begin m6 = 6'b110101; p6 = 6'b001010; end
        5'd5:  begin m6 = 6'b101001; p6 = 6'b101001; end
        5'd6:  begin m6 = 6'b011001; p6 = 6'b011001; end
        5'd7:  begin m6 = 6'b111000; p6 = 6'b000111; end
        5'd8:  begin m6 = 6'b111001; p6 = 6'b000110; end
        5'd9:  begin m6 = 6'b100101; p6 = 6'b100101; end
        5'd10: begin m6 = 6'b010101; p6 = 6'b010101; end
        5'd11: begin m6 = 6'b110100; p6 = 6'b110100; end
        5'd12: begin m6 = 6'b001101; p6 = 6'b001101; end
        5'd13: begin m6 = 6'b101100; p6 = 6'b101100; end
        5'd14: begin m6 = 6'b011100; p6 = 6'b011100; end
        5'd15: begin m6 = 6'b010111; p6 = 6'b101000; end
        5'd16: begin m6 = 6'b011011; p6 = 6'b100100; end
        5'd17: begin m6 = 6'b100011; p6 = 6'b100011; end
        5'd18: begin m6 = 6'b010011; p6 = 6'b010011; end
        5'd19: begin m6 = 6'b110010; p6 = 6'b110010; end
        5'd20: begin m6 = 6'b001011; p6 = 6'b001011; end
        5'd21: begin m6 = 6'b101010; p6 = 6'b101010; end
        5'd22: begin m6 = 6'b011010; p6 = 6'b011010; end
        5'd23: begin m6 = 6'b111010; p6 = 6'b000101; end
        5'd24: begin m6 = 6'b110011; p6 = 6'b001100; end
        5'd25: begin m6 = 6'b100110; p6 = 6'b100110; end
        5'd26: begin m6 = 6'b010110; p6 = 6'b010110; end
        5'd27: begin m6 = 6'b110110; p6 = 6'b001001; end
        5'd28: begin m6 = 6'b001110; p6 = 6'b001110; end
        5'd29: begin m6 = 6'b101110; p6 = 6'b010001; end
        5'd30: begin m6 = 6'b011110; p6 = 6'b100001; end
        default: begin m6 = 6'b101011; p6 = 6'b010100; end
      endcase
    end
    sb6    = rd ? p6 : m6;
    rd_mid = rd ^ ($countones(sb6) != 3);
  end

  // 3b/4b: column chosen by the disparity left after the 6b sub-block.
  always_comb begin
    m4      = 4'b0000;
    p4      = 4'b0000;
    use_alt = !control && (y3 == 3'd7) &&
              (rd_mid ? ((x5 == 5'd11) || (x5 == 5'd13) || (x5 == 5'd14))
                      : ((x5 == 5'd17) || (x5 == 5'd18) || (x5 == 5'd20)));
    if (control) begin
      case (y3)
        3'd0:    begin m4 = 4'b1011; p4 = 4'b0100; end
        3'd1:    begin m4 = 4'b0110; p4 = 4'b1001; end
        3'd2:    begin m4 = 4'b1010; p4 = 4'b0101; end
        3'd3:    begin m4 = 4'b1100; p4 = 4'b0011; end
        3'd4:    begin m4 = 4'b1101; p4 = 4'b0010; end
        3'd5:    begin m4 = 4'b0101; p4 = 4'b1010; end
        3'd6:    begin m4 = 4'b1001; p4 = 4'b0110; end
        default: begin m4 = 4'b0111; p4 = 4'b1000; end
      endcase
    end else begin
      case (y3)
        3'd0:    begin m4 = 4'b1011; p4 = 4'b0100; end
        3'd1:    begin m4 = 4'b1001; p4 = 4'b1001; end
        3'd2:    begin m4 = 4'b0101; p4 = 4'b0101; end
        3'd3:    begin m4 = 4'b1100; p4 = 4'b0011; end
        3'd4:    begin m4 = 4'b1101; p4 = 4'b0010; end
        3'd5:    begin m4 = 4'b1010; p4 = 4'b1010; end
        3'd6:    begin m4 = 4'b0110; p4 = 4'b0110; end
        default: begin
          m4 = use_alt ? 4'b0111 : 4'b1110;
          p4 = use_alt ? 4'b1000 : 4'b0001;
        end
      endcase
    end
    sb4    = rd_mid ? p4 : m4;
    rd_new = rd_mid ^ ($countones(sb4) != 2);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      data_10b  <= 10'b0;
      code_err  <= 1'b0;
      rd        <= INIT_RD;
    end else if (accept) begin
      out_valid <= 1'b1;
      data_10b  <= {sb6, sb4};
      code_err  <= err_nxt;
      rd        <= rd_new;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_enc_8b10b.sv
// Self-checking bench for enc_8b10b: directed code groups, stall/reset scenarios and
// a randomized stream compared against a table-plus-popcount reference model.
module tb_enc_8b10b;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] data;
  logic       control;
  logic [9:0] data_10b;
  logic       out_valid;
  logic       out_ready;
  logic       code_err;
  logic       rd;

  int total = 0;
  int bad   = 0;

  enc_8b10b #(.INIT_RD(1'b0)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .data(data), .control(control), .data_10b(data_10b), .out_valid(out_valid),
    .out_ready(out_ready), .code_err(code_err), .rd(rd)
  );

  always #5 clk = ~clk;

  // RD- 6b codes for D.0..D.31 (abcdei).
  localparam logic [5:0] T6 [0:31] = '{
    6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
    6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
    6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
    6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
  localparam logic [3:0] T4D [0:7] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100,
                                       4'b1101, 4'b1010, 4'b0110, 4'b1110};
  localparam logic [3:0] T4K [0:7] = '{4'b1011, 4'b0110, 4'b1010, 4'b1100,
                                       4'b1101, 4'b0101, 4'b1001, 4'b0111};

  // Returns {err, code}; RD+ forms are complements of the RD- forms where the rules demand.
  function automatic logic [10:0] ref_enc(input logic [7:0] b, input logic k, input logic r);
    logic       err;
    logic [4:0] x;
    logic [2:0] y;
    logic [5:0] s6;
    logic [3:0] s4;
    logic       rm;
    logic       alt;
    err = k && !((b[4:0] == 5'd28) || (b == 8'hF7) || (b == 8'hFB) || (b == 8'hFD) || (b == 8'hFE));
    if (err) b = 8'hBC;
    x  = b[4:0];
    y  = b[7:5];
    s6 = (k && x == 5'd28) ? 6'b001111 : T6[x];
    if (r && (($countones(s6) != 3) || (x == 5'd7))) s6 = ~s6;
    rm  = r ^ ($countones(s6) != 3);
    alt = !k && (y == 3'd7) &&
          (rm ? (x == 5'd11 || x == 5'd13 || x == 5'd14) : (x == 5'd17 || x == 5'd18 || x == 5'd20));
    s4 = k ? T4K[y] : (alt ? 4'b0111 : T4D[y]);
    if (rm && (k || ($countones(s4) != 2) || (y == 3'd3))) s4 = ~s4;
    return {err, s6, s4};
  endfunction

  function automatic logic ref_rd(input logic [9:0] c, input logic r);
    int n;
    n = $countones(c);
    return (n > 5) ? 1'b1 : ((n < 5) ? 1'b0 : r);
  endfunction

  task automatic drive_word(input logic [7:0] b, input logic k);
    in_valid = 1'b1;
    data     = b;
    control  = k;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic apply_reset();
    in_valid = 1'b0;
    reset    = 1'b0;
    #3;
    reset    = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (data_10b !== 10'b0) begin bad++; $display("FAIL reset_data got=%b exp=0", data_10b); end
    total++; if (code_err !== 1'b0) begin bad++; $display("FAIL reset_code_err got=%b exp=0", code_err); end
    total++; if (rd !== 1'b0) begin bad++; $display("FAIL reset_rd got=%b exp=0", rd); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_d00();
    drive_word(8'h00, 1'b0);
    total++; if (data_10b !== 10'b1001110100) begin bad++; $display("FAIL d00_code got=%b exp=1001110100", data_10b); end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL d00_valid got=%b exp=1", out_valid); end
    total++; if (rd !== 1'b0) begin bad++; $display("FAIL d00_rd got=%b exp=0", rd); end
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL d00_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_k28_5();
    drive_word(8'hBC, 1'b1);
    total++; if (data_10b !== 10'b0011111010) begin bad++; $display("FAIL k285_a got=%b exp=0011111010", data_10b); end
    total++; if (rd !== 1'b1) begin bad++; $display("FAIL k285_a_rd got=%b exp=1", rd); end
    total++; if (code_err !== 1'b0) begin bad++; $display("FAIL k285_a_err got=%b exp=0", code_err); end
    drive_word(8'hBC, 1'b1);
    total++; if (data_10b !== 10'b1100000101) begin bad++; $display("FAIL k285_b got=%b exp=1100000101", data_10b); end
    total++; if (rd !== 1'b0) begin bad++; $display("FAIL k285_b_rd got=%b exp=0", rd); end
  endtask

  task automatic test_d17_d21();
    drive_word(8'hF1, 1'b0);
    total++; if (data_10b !== 10'b1000110111) begin bad++; $display("FAIL d17_7 got=%b exp=1000110111", data_10b); end
    total++; if (rd !== 1'b1) begin bad++; $display("FAIL d17_7_rd got=%b exp=1", rd); end
    drive_word(8'hB5, 1'b0);
    total++; if (data_10b !== 10'b1010101010) begin bad++; $display("FAIL d21_5 got=%b exp=1010101010", data_10b); end
    total++; if (rd !== 1'b1) begin bad++; $display("FAIL d21_5_rd got=%b exp=1", rd); end
  endtask

  task automatic test_code_err();
    apply_reset();
    drive_word(8'h00, 1'b1);
    total++; if (code_err !== 1'b1) begin bad++; $display("FAIL cerr_flag got=%b exp=1", code_err); end
    total++; if (data_10b !== 10'b0011111010) begin bad++; $display("FAIL cerr_code got=%b exp=0011111010", data_10b); end
    total++; if (rd !== 1'b1) begin bad++; $display("FAIL cerr_rd got=%b exp=1", rd); end
    drive_word(8'h00, 1'b0);
    total++; if (code_err !== 1'b0) begin bad++; $display("FAIL cerr_next_flag got=%b exp=0", code_err); end
    total++; if (data_10b !== 10'b0110001011) begin bad++; $display("FAIL cerr_next_code got=%b exp=0110001011", data_10b); end
  endtask

  task automatic test_stall();
    logic [7:0]  w [0:3];
    logic [10:0] e;
    logic [9:0]  code_a;
    logic        m_rd;
    logic        rd_a;
    w[0] = 8'h3C; w[1] = 8'h4A; w[2] = 8'h95; w[3] = 8'hE7;
    m_rd = 1'b1;
    out_ready = 1'b1;
    drive_word(w[0], 1'b0);
    e = ref_enc(w[0], 1'b0, m_rd); code_a = e[9:0]; m_rd = ref_rd(code_a, m_rd); rd_a = m_rd;
    total++; if (data_10b !== code_a) begin bad++; $display("FAIL stall_a got=%b exp=%b", data_10b, code_a); end
    out_ready = 1'b0; in_valid = 1'b1; data = w[1]; control = 1'b0;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_ready got=%b exp=0", in_ready); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++; if (data_10b !== code_a) begin bad++; $display("FAIL stall_hold%0d got=%b exp=%b", i, data_10b, code_a); end
      total++; if (rd !== rd_a) begin bad++; $display("FAIL stall_rd%0d got=%b exp=%b", i, rd, rd_a); end
      total++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin bad++; $display("FAIL stall_hs%0d got=%b%b exp=10", i, out_valid, in_ready); end
    end
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stall_resume_ready got=%b exp=1", in_ready); end
    for (int i = 1; i < 4; i++) begin
      data = w[i];
      @(posedge clk); #1;
      e = ref_enc(w[i], 1'b0, m_rd); m_rd = ref_rd(e[9:0], m_rd);
      total++; if (data_10b !== e[9:0] || out_valid !== 1'b1) begin bad++; $display("FAIL stall_word%0d got=%b exp=%b", i, data_10b, e[9:0]); end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stall_no_dup got=%b exp=0", out_valid); end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    drive_word(8'h55, 1'b0);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL mid_pre_valid got=%b exp=1", out_valid); end
    #2;
    reset = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_async_valid got=%b exp=0", out_valid); end
    total++; if (rd !== 1'b0) begin bad++; $display("FAIL mid_async_rd got=%b exp=0", rd); end
    total++; if (data_10b !== 10'b0) begin bad++; $display("FAIL mid_async_data got=%b exp=0", data_10b); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_async_ready got=%b exp=1", in_ready); end
    @(posedge clk); #3;
    reset = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    drive_word(8'hF1, 1'b0);
    total++; if (data_10b !== 10'b1000110111) begin bad++; $display("FAIL mid_first_word got=%b exp=1000110111", data_10b); end
  endtask

  task automatic test_random_stream();
    logic [8:0]  words [$];
    logic [8:0]  tmp;
    logic        m_valid;
    logic [9:0]  m_data;
    logic        m_err;
    logic        m_rd;
    logic        exp_ready;
    logic        acc;
    logic [10:0] e;
    int          idx;
    int          j;
    int          cyc;
    int          drain;
    for (int i = 0; i < 256; i++) words.push_back({1'b0, 8'(i)});
    for (int i = 0; i < 8; i++) words.push_back({1'b1, 3'(i), 5'd28});
    words.push_back({1'b1, 8'hF7}); words.push_back({1'b1, 8'hFB});
    words.push_back({1'b1, 8'hFD}); words.push_back({1'b1, 8'hFE});
    for (int i = 0; i < 40; i++) words.push_back(9'($urandom));
    for (int i = words.size() - 1; i > 0; i--) begin
      j = $urandom_range(0, i);
      tmp = words[i]; words[i] = words[j]; words[j] = tmp;
    end
    apply_reset();
    m_valid = 1'b0; m_data = 10'b0; m_err = 1'b0; m_rd = 1'b0;
    idx = 0; cyc = 0; drain = 0;
    while (drain < 4 && cyc < 5000) begin
      cyc++;
      if (idx >= words.size()) drain++;
      in_valid  = (idx < words.size()) && ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      if (in_valid) {control, data} = words[idx];
      else {control, data} = 9'($urandom);
      #1;
      exp_ready = !m_valid || out_ready;
      total++; if (in_ready !== exp_ready) begin bad++; $display("FAIL rnd_in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, exp_ready); end
      acc = in_valid && exp_ready;
      @(posedge clk);
      if (acc) begin
        e = ref_enc(data, control, m_rd);
        m_err = e[10]; m_data = e[9:0]; m_rd = ref_rd(e[9:0], m_rd); m_valid = 1'b1;
        idx++;
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
      #1;
      total++; if (out_valid !== m_valid) begin bad++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, out_valid, m_valid); end
      total++; if (rd !== m_rd) begin bad++; $display("FAIL rnd_rd cyc=%0d got=%b exp=%b", cyc, rd, m_rd); end
      if (m_valid) begin
        total++; if (data_10b !== m_data || code_err !== m_err) begin bad++; $display("FAIL rnd_code cyc=%0d got=%b/%b exp=%b/%b", cyc, data_10b, code_err, m_data, m_err); end
      end
    end
    in_valid = 1'b0;
    total++; if (idx != words.size()) begin bad++; $display("FAIL rnd_budget sent=%0d exp=%0d", idx, words.size()); end
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; data = 8'h00; control = 1'b0; out_ready = 1'b1;
    test_reset();
    test_d00();
    test_k28_5();
    test_d17_d21();
    test_code_err();
    test_stall();
    test_reset_midstream();
    test_random_stream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/enc_8b10b.md
ENC_8B10B -- requirements
Module: enc_8b10b

Interface
REQ-001 SHALL have parameter INIT_RD, default 1'b0, running disparity loaded at reset (0 = RD-, 1 = RD+).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_valid  input  1  data/control hold a word to encode.
REQ-005 SHALL have port in_ready  output  1  encoder accepts a word this cycle.
REQ-006 SHALL have port data  input  8  byte HGFEDCBA; data[4:0]=EDCBA (5b part), data[7:5]=HGF (3b part).
REQ-007 SHALL have port control  input  1  1 = encode as K character, 0 = D character.
REQ-008 SHALL have port data_10b  output  10  code group; [9:4]=abcdei, [3:0]=fghj; bit 9 transmitted first.
REQ-009 SHALL have port out_valid  output  1  data_10b holds a valid code group.
REQ-010 SHALL have port out_ready  input  1  downstream consumes data_10b this cycle.
REQ-011 SHALL have port code_err  output  1  accompanies data_10b; the word was an illegal K request.
REQ-012 SHALL have port rd  output  1  current running disparity (0 = RD-, 1 = RD+) after last accepted word.

Function
REQ-013 SHALL accept a word when in_valid && in_ready; in_ready = !out_valid || out_ready (combinational).
REQ-014 SHALL register the encoded group: data_10b, code_err, out_valid valid one cycle after acceptance (latency 1).
REQ-015 SHALL hold data_10b, code_err stable while out_valid && !out_ready.
REQ-016 SHALL clear out_valid when out_ready && out_valid and no word accepted in the same cycle; accept+consume same cycle keeps out_valid=1 with new group (full throughput).
REQ-017 SHALL encode 5b/6b per IEEE 802.3 Clause 36 tables, selecting RD- or RD+ column by current rd.
REQ-018 SHALL compute intermediate disparity after the 6b sub-block: flip if sub-block has unequal ones/zeros, else unchanged (D.07: 111000 at RD-, 000111 at RD+, no flip).
REQ-019 SHALL encode 3b/4b selecting column by intermediate disparity; flip again if 4b sub-block unbalanced; result becomes new rd.
REQ-020 SHALL use alternate D.x.A7 (0111 at RD-, 1000 at RD+) when x∈{17,18,20} at RD- or x∈{11,13,14} at RD+; otherwise P7 (1110 at RD-, 0001 at RD+).
REQ-021 SHALL accept K28.0..K28.7, K23.7, K27.7, K29.7, K30.7 when control=1; K28.y uses 001111/110000 and K.x.7 uses 0111/1000 per Clause 36.
REQ-022 SHALL, for any other control=1 byte, set code_err=1 with that group and emit K28.5 with normal disparity update.
REQ-023 SHALL update rd only on acceptance; stalls leave rd unchanged.
REQ-024 SHALL ignore data/control when in_valid=0 or in_ready=0.

Reset
REQ-025 SHALL on reset low, asynchronously: out_valid=0, data_10b=10'b0, code_err=0, rd=INIT_RD.
REQ-026 SHALL drop an in-flight group on reset mid-stream; first word after release encodes with rd=INIT_RD.
REQ-027 SHALL have in_ready=1 throughout and after reset (out_valid=0).

Verification
REQ-028 SHALL verify: reset release, out_ready=1, D.00 (control=0, data=0x00) -> next cycle data_10b=1001110100, out_valid=1, rd=0.
REQ-029 SHALL verify: from rd=0, K28.5 (0xBC, control=1) then K28.5 -> 0011111010 (rd=1) then 1100000101 (rd=0).
REQ-030 SHALL verify: from rd=0, D.17.7 (0xF1) -> 1000110111, rd=1; then D.21.5 (0xB5) -> 1010101010, rd stays 1.
REQ-031 SHALL verify: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, data_10b and rd frozen; one-per-cycle resumes on out_ready=1, no word lost or duplicated.
REQ-032 SHALL verify: control=1, data=0x00 at rd=0 -> code_err=1, data_10b=0011111010, rd=1; next legal word code_err=0.
REQ-033 SHALL verify: reset asserted with out_valid=1 -> out_valid=0, rd=INIT_RD immediately, no clock edge required; all 256 D and 12 K codes then match a reference model over random streams.
